// File: rtl/m6809_bus_master.sv
// ---------------------------------------------------------------------------
// m6809_bus_master
//
// Generates 6809-style bus cycles (E clock, address, R/W, data) from a
// simple valid/ready request interface. Every bus cycle is four clk long
// (ph0..ph3), with E high during ph2/ph3. A real access can be stretched at
// ph3 by the responder holding bus_ready low, up to STRETCH_MAX extra clocks.
// After that limit the access ends with an error. When no request is
// accepted, the bus runs dummy cycles at address FFFF, read, data not driven.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   req_valid/req_ready     request handshake, accepted on clk edge when both high
//   req_addr/rnw/wdata      captured on acceptance
//   rsp_valid/rdata/err     one-clk completion pulse with read data / timeout flag
//   bus_e                   E clock (registered)
//   bus_adr/bus_rnw         bus address and read/not-write (registered)
//   bus_dout/bus_doe        write data and its output enable (tristate external)
//   bus_din/bus_ready       read data and responder ready from the bus
//   busy                    a real access occupies the current bus cycle
// ---------------------------------------------------------------------------
module m6809_bus_master #(
    parameter int unsigned STRETCH_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_rnw,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        bus_e,
    output logic [15:0] bus_adr,
    output logic        bus_rnw,
    output logic [7:0]  bus_dout,
    output logic        bus_doe,
    input  logic [7:0]  bus_din,
    input  logic        bus_ready,
    output logic        busy
);

    localparam logic [7:0] SMAX = STRETCH_MAX[7:0];

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

    phase_e      ph_q, ph_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        active_q, active_d;
    logic        bus_e_q, bus_e_d;
    logic [15:0] bus_adr_q, bus_adr_d;
    logic        bus_rnw_q, bus_rnw_d;
    logic [7:0]  bus_dout_q, bus_dout_d;
    logic        bus_doe_q, bus_doe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic stall;
    logic term;
    logic accept;

    always_comb begin
        // A real access holds in ph3 while the responder is not ready and
        // the stretch budget is not yet used up.
        stall = (ph_q == PH3) && active_q && !bus_ready && (cnt_q < SMAX);
        // Every bus cycle (dummy or real) terminates on a non-stalled ph3.
        term   = (ph_q == PH3) && !stall;
        accept = req_valid && term && !reset;

        ph_d  = stall ? PH3 : phase_e'(ph_q + 2'd1);
        cnt_d = stall ? (cnt_q + 8'd1) : '0;

        active_d   = active_q;
        bus_adr_d  = bus_adr_q;
        bus_rnw_d  = bus_rnw_q;
        bus_dout_d = bus_dout_q;
        if (term) begin
            active_d = accept;
            if (accept) begin
                bus_adr_d  = req_addr;
                bus_rnw_d  = req_rnw;
                bus_dout_d = req_wdata;
            end else begin
                bus_adr_d  = 16'hFFFF;
                bus_rnw_d  = 1'b1;
                bus_dout_d = '0;
            end
        end

        bus_e_d   = (ph_d == PH2) || (ph_d == PH3);
        bus_doe_d = bus_e_d && active_d && !bus_rnw_d;

        // Termination of a real access with bus_ready still low can only be
        // the timeout case, since otherwise the cycle would have stalled.
        rsp_valid_d = term && active_q;
        rsp_err_d   = rsp_valid_d && !bus_ready;
        rsp_rdata_d = (rsp_valid_d && bus_ready && bus_rnw_q) ? bus_din : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q        <= PH0;
            cnt_q       <= '0;
            active_q    <= 1'b0;
            bus_e_q     <= 1'b0;
            bus_adr_q   <= 16'hFFFF;
            bus_rnw_q   <= 1'b1;
            bus_dout_q  <= '0;
            bus_doe_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            bus_e_q     <= bus_e_d;
            bus_adr_q   <= bus_adr_d;
            bus_rnw_q   <= bus_rnw_d;
            bus_dout_q  <= bus_dout_d;
            bus_doe_q   <= bus_doe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // req_ready is combinational on bus_ready so a request can be taken in
    // the same clk a stretched access completes.
    assign req_ready = term && !reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign bus_e     = bus_e_q;
    assign bus_adr   = bus_adr_q;
    assign bus_rnw   = bus_rnw_q;
    assign bus_dout  = bus_dout_q;
    assign bus_doe   = bus_doe_q;
    assign busy      = active_q;

endmodule
